// File: rtl/tug_of_war_if.sv
// Board-level pin bundle for the tug-of-war game: switches, keys, LEDs and 7-segment digits.
// The master side drives switches/keys (board or bench); the slave side is the game logic.
interface tug_of_war_if;
    logic [9:0] SW;
    logic [3:0] KEY;
    logic [9:0] LEDR;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output SW, KEY,
        input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  SW, KEY,
        output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/tug_of_war_top.sv
// Tug-of-war: KEY[0] player versus an LFSR computer pulling one lit LED along LEDR[9:1].
// Single game clock, one-cycle pulse per press, wins re-centre the field and bump a saturating score.

module tow_clock_divider #(
    parameter int WHICH_CLOCK = 15
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);
    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (rst) count <= 32'd0;
        else     count <= count + 32'd1;
    end

    assign clk_out = count[WHICH_CLOCK];
endmodule

module tow_computer (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] threshold,
    output logic       comp_out
);
    logic [9:0] lfsr;

    // XNOR feedback keeps the all-zero reset state inside the sequence.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 10'd0;
        else     lfsr <= {lfsr[8:0], ~(lfsr[9] ^ lfsr[6])};
    end

    assign comp_out = ({1'b0, threshold} > lfsr);
endmodule

module tow_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);
    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    assign pulse = s1 & ~s2;
endmodule

module tow_light #(
    parameter bit RESET_ON = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic left,
    input  logic right,
    input  logic nl,
    input  logic nr,
    output logic on
);
    always_ff @(posedge clk) begin
        if (rst) on <= RESET_ON;
        else     on <= (left & ~right & nr) | (right & ~left & nl) | (on & ~(left ^ right));
    end
endmodule

module tow_victory (
    input  logic clk,
    input  logic rst,
    input  logic left,
    input  logic right,
    input  logic end_left,
    input  logic end_right,
    output logic p1_win,
    output logic p2_win
);
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_win <= 1'b0;
            p2_win <= 1'b0;
        end else begin
            p1_win <= end_left & left & ~right;
            p2_win <= end_right & right & ~left;
        end
    end
endmodule

module tow_score (
    input  logic       clk,
    input  logic       rst,
    input  logic       win,
    output logic [6:0] hex
);
    logic [2:0] score;

    always_ff @(posedge clk) begin
        if (rst)                        score <= 3'd0;
        else if (win && score != 3'd7)  score <= score + 3'd1;
    end

    always_comb begin
        hex = 7'b1111111;
        case (score)
            3'd0: hex = 7'b1000000;
            3'd1: hex = 7'b1111001;
            3'd2: hex = 7'b0100100;
            3'd3: hex = 7'b0110000;
            3'd4: hex = 7'b0011001;
            3'd5: hex = 7'b0010010;
            3'd6: hex = 7'b0000010;
            3'd7: hex = 7'b1111000;
            default: hex = 7'b1111111;
        endcase
    end
endmodule

module tug_of_war_top #(
    parameter int WHICH_CLOCK = 15,
    parameter int USE_DIV_CLK = 0
) (
    input logic         CLOCK_50,
    tug_of_war_if.slave board
);
    logic        game_clk;
    logic        div_clk_bit;
    logic        rst;
    logic        playfield_reset;
    logic        comp_out;
    logic        left;
    logic        right;
    logic        p1_win;
    logic        p2_win;
    logic [10:0] field;

    assign rst             = board.SW[9] | playfield_reset;
    assign playfield_reset = p1_win | p2_win;

    tow_clock_divider #(.WHICH_CLOCK(WHICH_CLOCK)) u_div (
        .clk     (CLOCK_50),
        .rst     (rst),
        .clk_out (div_clk_bit)
    );

    assign game_clk = (USE_DIV_CLK != 0) ? div_clk_bit : CLOCK_50;

    tow_computer u_comp (
        .clk       (game_clk),
        .rst       (rst),
        .threshold (board.SW[8:0]),
        .comp_out  (comp_out)
    );

    tow_edge_detect u_edge_p1 (
        .clk   (game_clk),
        .rst   (rst),
        .in    (~board.KEY[0]),
        .pulse (left)
    );

    tow_edge_detect u_edge_p2 (
        .clk   (game_clk),
        .rst   (rst),
        .in    (comp_out),
        .pulse (right)
    );

    // field[0] and field[10] are the dark neighbours beyond each end of the playfield.
    assign field[0]  = 1'b0;
    assign field[10] = 1'b0;

    for (genvar i = 1; i <= 9; i++) begin : g_light
        tow_light #(.RESET_ON(i == 5)) u_light (
            .clk   (game_clk),
            .rst   (rst),
            .left  (left),
            .right (right),
            .nl    (field[i-1]),
            .nr    (field[i+1]),
            .on    (field[i])
        );
    end

    tow_victory u_victory (
        .clk       (game_clk),
        .rst       (rst),
        .left      (left),
        .right     (right),
        .end_left  (field[1]),
        .end_right (field[9]),
        .p1_win    (p1_win),
        .p2_win    (p2_win)
    );

    // Scores survive playfield re-centring; only the board reset clears them.
    tow_score u_score_p1 (
        .clk (game_clk),
        .rst (board.SW[9]),
        .win (p1_win),
        .hex (board.HEX0)
    );

    tow_score u_score_p2 (
        .clk (game_clk),
        .rst (board.SW[9]),
        .win (p2_win),
        .hex (board.HEX5)
    );

    assign board.LEDR = {field[9:1], 1'b0};
    assign board.HEX1 = 7'b1111111;
    assign board.HEX2 = 7'b1111111;
    assign board.HEX3 = 7'b1111111;
    assign board.HEX4 = 7'b1111111;
endmodule

// File: tb/tb_tug_of_war_top.sv
// Directed bench for tug_of_war_top: reset, idle computer, player 1 wins, held key,
// mid-game reset, aggressive computer, score saturation and global reset.
module tb_tug_of_war_top;
    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    tug_of_war_if board ();

    tug_of_war_top #(.WHICH_CLOCK(15), .USE_DIV_CLK(0)) dut (
        .CLOCK_50 (clk),
        .board    (board.slave)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] CENTRE = 10'b0000100000;
    localparam logic [6:0] BLANK  = 7'b1111111;

    function automatic logic [6:0] seg_exp(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            default: return 7'b1111000;
        endcase
    endfunction

    function automatic int led_pos(input logic [9:0] l);
        int p = 0;
        for (int i = 1; i <= 9; i++) if (l[i]) p = i;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        board.SW[9] = 1'b1;
        step();
        board.SW[9] = 1'b0;
    endtask

    task automatic press_release();
        board.KEY[0] = 1'b0;
        step();
        board.KEY[0] = 1'b1;
        step();
    endtask

    task automatic test_reset();
        board.SW  = 10'h200;
        board.KEY = 4'hF;
        step();
        board.SW = 10'h000;
        n_checks++;
        if (board.LEDR !== CENTRE) begin
            n_fail++; $display("FAIL reset_ledr: got %b want %b", board.LEDR, CENTRE);
        end
        n_checks++;
        if (board.HEX0 !== seg_exp(0)) begin
            n_fail++; $display("FAIL reset_hex0: got %b want %b", board.HEX0, seg_exp(0));
        end
        n_checks++;
        if (board.HEX5 !== seg_exp(0)) begin
            n_fail++; $display("FAIL reset_hex5: got %b want %b", board.HEX5, seg_exp(0));
        end
        n_checks++;
        if ({board.HEX1, board.HEX2, board.HEX3, board.HEX4} !== {4{BLANK}}) begin
            n_fail++; $display("FAIL reset_blank: got %b want %b",
                               {board.HEX1, board.HEX2, board.HEX3, board.HEX4}, {4{BLANK}});
        end
    endtask

    task automatic test_idle();
        do_reset();
        board.SW[8:0] = 9'd0;
        board.KEY     = 4'hF;
        repeat (100) step();
        n_checks++;
        if (board.LEDR !== CENTRE) begin
            n_fail++; $display("FAIL idle_ledr: got %b want %b", board.LEDR, CENTRE);
        end
        n_checks++;
        if ({board.HEX0, board.HEX5} !== {seg_exp(0), seg_exp(0)}) begin
            n_fail++; $display("FAIL idle_score: got %b/%b want %b/%b",
                               board.HEX0, board.HEX5, seg_exp(0), seg_exp(0));
        end
    endtask

    task automatic test_p1_win();
        logic [9:0] exp;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            press_release();
            exp = CENTRE >> k;
            n_checks++;
            if (board.LEDR !== exp) begin
                n_fail++; $display("FAIL p1_step%0d: got %b want %b", k, board.LEDR, exp);
            end
        end
        press_release();
        n_checks++;
        if (board.LEDR !== 10'd0) begin
            n_fail++; $display("FAIL p1_dark: got %b want %b", board.LEDR, 10'd0);
        end
        n_checks++;
        if (board.HEX0 !== seg_exp(0)) begin
            n_fail++; $display("FAIL p1_score_early: got %b want %b", board.HEX0, seg_exp(0));
        end
        step();
        n_checks++;
        if (board.LEDR !== CENTRE) begin
            n_fail++; $display("FAIL p1_recentre: got %b want %b", board.LEDR, CENTRE);
        end
        n_checks++;
        if (board.HEX0 !== seg_exp(1)) begin
            n_fail++; $display("FAIL p1_score: got %b want %b", board.HEX0, seg_exp(1));
        end
        n_checks++;
        if (board.HEX5 !== seg_exp(0)) begin
            n_fail++; $display("FAIL p1_hex5: got %b want %b", board.HEX5, seg_exp(0));
        end
        step();
        n_checks++;
        if (board.HEX0 !== seg_exp(1)) begin
            n_fail++; $display("FAIL p1_single_inc: got %b want %b", board.HEX0, seg_exp(1));
        end
    endtask

    task automatic test_held_key();
        do_reset();
        board.KEY[0] = 1'b0;
        repeat (10) step();
        n_checks++;
        if (board.LEDR !== 10'b0000010000) begin
            n_fail++; $display("FAIL held_key: got %b want %b", board.LEDR, 10'b0000010000);
        end
        board.KEY[0] = 1'b1;
        repeat (2) step();
        n_checks++;
        if (board.LEDR !== 10'b0000010000) begin
            n_fail++; $display("FAIL held_release: got %b want %b", board.LEDR, 10'b0000010000);
        end
    endtask

    task automatic test_midgame_reset();
        press_release();
        press_release();
        n_checks++;
        if (board.LEDR !== 10'b0000000100) begin
            n_fail++; $display("FAIL mid_pos: got %b want %b", board.LEDR, 10'b0000000100);
        end
        do_reset();
        n_checks++;
        if (board.LEDR !== CENTRE) begin
            n_fail++; $display("FAIL mid_reset: got %b want %b", board.LEDR, CENTRE);
        end
    endtask

    task automatic test_aggressive();
        logic [9:0] prev;
        logic [9:0] at_win;
        logic [9:0] before_win;
        bit         found;
        bit         mono_ok = 1'b1;
        int         pos;
        int         prev_pos;
        do_reset();
        board.SW[8:0] = 9'h1FF;
        board.KEY     = 4'hF;
        for (int w = 1; w <= 2; w++) begin
            found = 1'b0;
            for (int c = 0; c < 2000 && !found; c++) begin
                prev = board.LEDR;
                step();
                if (board.HEX5 === seg_exp(w)) begin
                    found      = 1'b1;
                    at_win     = board.LEDR;
                    before_win = prev;
                end else begin
                    pos      = led_pos(board.LEDR);
                    prev_pos = led_pos(prev);
                    if (pos != 0 && prev_pos != 0 && pos < prev_pos) mono_ok = 1'b0;
                end
            end
            n_checks++;
            if (!found) begin
                n_fail++; $display("FAIL comp_win%0d_timeout: hex5 %b want %b", w, board.HEX5, seg_exp(w));
            end else begin
                n_checks++;
                if (at_win !== CENTRE) begin
                    n_fail++; $display("FAIL comp_recentre%0d: got %b want %b", w, at_win, CENTRE);
                end
                n_checks++;
                if (before_win !== 10'd0) begin
                    n_fail++; $display("FAIL comp_dark%0d: got %b want %b", w, before_win, 10'd0);
                end
            end
        end
        n_checks++;
        if (!mono_ok) begin
            n_fail++; $display("FAIL comp_upward: got downward step want upward only");
        end
        n_checks++;
        if (board.HEX0 !== seg_exp(0)) begin
            n_fail++; $display("FAIL comp_hex0: got %b want %b", board.HEX0, seg_exp(0));
        end
        board.SW[8:0] = 9'd0;
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        board.SW[8:0] = 9'd0;
        for (int w = 1; w <= 8; w++) begin
            repeat (5) press_release();
            step();
            want = (w > 7) ? 7 : w;
            n_checks++;
            if (board.HEX0 !== seg_exp(want)) begin
                n_fail++; $display("FAIL sat_win%0d: got %b want %b", w, board.HEX0, seg_exp(want));
            end
        end
        n_checks++;
        if (board.LEDR !== CENTRE) begin
            n_fail++; $display("FAIL sat_ledr: got %b want %b", board.LEDR, CENTRE);
        end
        do_reset();
        n_checks++;
        if ({board.HEX0, board.HEX5} !== {seg_exp(0), seg_exp(0)}) begin
            n_fail++; $display("FAIL global_reset: got %b/%b want %b/%b",
                               board.HEX0, board.HEX5, seg_exp(0), seg_exp(0));
        end
    endtask

    initial begin
        board.SW  = 10'h000;
        board.KEY = 4'hF;
        test_reset();
        test_idle();
        test_p1_win();
        test_held_key();
        test_midgame_reset();
        test_aggressive();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
